// File: rtl/fu_wb_queue.sv
// rtl/fu_wb_queue.sv - FU writeback queue feeding one PRF write port and the ROB finish port
module fu_wb_queue #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 32,
  parameter int PRF_AW = 6,
  parameter int ROB_W  = 6
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic                       in_wen,
  input  logic [PRF_AW-1:0]          in_prf_addr,
  input  logic [DATA_W-1:0]          in_data,
  input  logic [ROB_W-1:0]           in_rob_id,
  output logic                       out_valid,
  input  logic                       out_grant,
  output logic                       prf_wen,
  output logic [PRF_AW-1:0]          prf_addr,
  output logic [DATA_W-1:0]          prf_data,
  output logic                       rob_finish,
  output logic [ROB_W-1:0]           rob_id,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  // Entry storage; wen is kept separately so flush can invalidate it cheaply.
  logic              e_wen  [DEPTH];
  logic [PRF_AW-1:0] e_addr [DEPTH];
  logic [DATA_W-1:0] e_data [DEPTH];
  logic [ROB_W-1:0]  e_rob  [DEPTH];

  logic [PW-1:0] head;
  logic [PW-1:0] tail;
  logic [CW-1:0] cnt_q;

  logic push;
  logic pop;

  // Ready looks only at occupancy so there is no grant-to-ready combinational path.
  assign in_ready  = (cnt_q != FULL_CNT);
  assign out_valid = (cnt_q != '0);
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_grant;
  assign count     = cnt_q;

  // Head entry drives the writeback ports straight from registers.
  assign prf_addr   = e_addr[head];
  assign prf_data   = e_data[head];
  assign rob_id     = e_rob[head];
  assign rob_finish = pop;
  assign prf_wen    = pop & e_wen[head];

  // Pointer and occupancy update; flush and reset both empty the queue.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      head  <= '0;
      tail  <= '0;
      cnt_q <= '0;
    end else begin
      if (push) tail <= tail + PW'(1);
      if (pop)  head <= head + PW'(1);
      case ({push, pop})
        2'b10:   cnt_q <= cnt_q + CW'(1);
        2'b01:   cnt_q <= cnt_q - CW'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  // Entry write at tail; reset clears every field, flush only invalidates wen.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        e_wen[i]  <= 1'b0;
        e_addr[i] <= '0;
        e_data[i] <= '0;
        e_rob[i]  <= '0;
      end
    end else if (flush) begin
      for (int i = 0; i < DEPTH; i++) begin
        e_wen[i] <= 1'b0;
      end
    end else if (push) begin
      e_wen[tail]  <= in_wen;
      e_addr[tail] <= in_prf_addr;
      e_data[tail] <= in_data;
      e_rob[tail]  <= in_rob_id;
    end
  end

endmodule

// File: tb/tb_fu_wb_queue.sv
// tb/tb_fu_wb_queue.sv - vector table, hand sequences and reference-model bench for fu_wb_queue
module tb_fu_wb_queue;

  logic        clk = 1'b0;
  logic        rst, flush, in_valid, in_wen, out_grant;
  logic [5:0]  in_prf_addr, in_rob_id;
  logic [31:0] in_data;
  logic        in_ready, out_valid, prf_wen, rob_finish;
  logic [5:0]  prf_addr, rob_id;
  logic [31:0] prf_data;
  logic [2:0]  count;

  int pass_cnt = 0;
  int total_cnt = 0;

  always #5 clk = ~clk;

  fu_wb_queue #(.DEPTH(4), .DATA_W(32), .PRF_AW(6), .ROB_W(6)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_wen(in_wen),
    .in_prf_addr(in_prf_addr), .in_data(in_data), .in_rob_id(in_rob_id),
    .out_valid(out_valid), .out_grant(out_grant),
    .prf_wen(prf_wen), .prf_addr(prf_addr), .prf_data(prf_data),
    .rob_finish(rob_finish), .rob_id(rob_id), .count(count)
  );

  typedef struct {
    logic rst, flush, iv, wen;
    logic [5:0] addr; logic [31:0] data; logic [5:0] rob;
    logic grant;
    logic chk;
    logic [2:0] e_cnt;
    logic e_rdy, e_vld, e_pwen, e_fin;
    logic [5:0] e_addr; logic [31:0] e_data; logic [5:0] e_rob;
  } vec_t;

  typedef struct {
    logic wen; logic [5:0] addr; logic [31:0] data; logic [5:0] rob;
  } ent_t;

  vec_t vt[$];
  ent_t mq[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  function automatic vec_t v(input logic r, fl, iv, wen, input logic [5:0] a, input logic [31:0] d,
                             input logic [5:0] rb, input logic g, input logic c, input logic [2:0] ec,
                             input logic erdy, evld, epw, efin, input logic [5:0] ea,
                             input logic [31:0] ed, input logic [5:0] er);
    vec_t x;
    x.rst = r; x.flush = fl; x.iv = iv; x.wen = wen; x.addr = a; x.data = d; x.rob = rb; x.grant = g;
    x.chk = c; x.e_cnt = ec; x.e_rdy = erdy; x.e_vld = evld; x.e_pwen = epw; x.e_fin = efin;
    x.e_addr = ea; x.e_data = ed; x.e_rob = er;
    return x;
  endfunction

  task automatic drive(input logic r, fl, iv, wen, input logic [5:0] a, input logic [31:0] d,
                       input logic [5:0] rb, input logic g);
    rst = r; flush = fl; in_valid = iv; in_wen = wen;
    in_prf_addr = a; in_data = d; in_rob_id = rb; out_grant = g;
    #1;
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Checks taken mid-cycle against the reference queue, then advances it by one edge.
  task automatic model_cycle(input logic iv, input ent_t e, input logic g, input logic fl, output logic accepted);
    logic exp_fin;
    drive(1'b0, fl, iv, e.wen, e.addr, e.data, e.rob, g);
    exp_fin = (mq.size() > 0) && g;
    chk("m_count", count, mq.size());
    chk("m_in_ready", in_ready, mq.size() != 4);
    chk("m_out_valid", out_valid, mq.size() > 0);
    chk("m_rob_finish", rob_finish, exp_fin);
    chk("m_prf_wen", prf_wen, exp_fin && mq[0].wen);
    if (mq.size() > 0) begin
      chk("m_rob_id", rob_id, mq[0].rob);
      chk("m_prf_addr", prf_addr, mq[0].addr);
      chk("m_prf_data", prf_data, mq[0].data);
    end
    accepted = iv && (mq.size() != 4) && !fl;
    if (fl) mq.delete();
    else begin
      if (exp_fin) void'(mq.pop_front());
      if (accepted) mq.push_back(e);
    end
    step();
  endtask

  task automatic run_model(input int cycles, input int mode);
    logic have = 1'b0;
    logic acc;
    ent_t pend;
    int produced = 0;
    int gpat[5] = '{1, 0, 1, 1, 0};
    logic g, fl;
    pend = '{1'b0, 6'd0, 32'd0, 6'd0};
    for (int c = 0; c < cycles; c++) begin
      if (!have && (mode == 0 ? produced < 10 : ($urandom % 4) != 0)) begin
        pend.wen  = 1'($urandom);
        pend.addr = 6'($urandom);
        pend.data = $urandom;
        pend.rob  = (mode == 0) ? 6'(produced + 20) : 6'($urandom);
        have = 1'b1;
        produced++;
      end
      g  = (mode == 0) ? 1'(gpat[c % 5]) : 1'($urandom_range(0, 2) != 0);
      fl = (mode == 0) ? 1'b0 : ($urandom % 30) == 0;
      model_cycle(have, pend, g, fl, acc);
      if (acc || fl) have = 1'b0;
    end
  endtask

  initial begin
    ent_t dummy;
    logic acc;
    drive(1'b1, 1'b0, 1'b0, 1'b0, 6'd0, 32'd0, 6'd0, 1'b0);
    @(negedge clk);

    vt.push_back(v(1,0,1,1, 6'd1, 32'h11, 6'd1, 0, 0, 0,1,0,0,0, 0, 0, 0));
    vt.push_back(v(1,0,1,1, 6'd1, 32'h11, 6'd1, 0, 1, 0,1,0,0,0, 0, 0, 0));
    vt.push_back(v(0,0,0,0, 6'd0, 32'h0, 6'd0, 1, 1, 0,1,0,0,0, 0, 0, 0));
    vt.push_back(v(0,0,1,1, 6'd5, 32'hDEADBEEF, 6'd3, 1, 1, 0,1,0,0,0, 0, 0, 0));
    vt.push_back(v(0,0,0,0, 6'd0, 32'h0, 6'd0, 1, 1, 1,1,1,1,1, 6'd5, 32'hDEADBEEF, 6'd3));
    vt.push_back(v(0,0,0,0, 6'd0, 32'h0, 6'd0, 0, 1, 0,1,0,0,0, 0, 0, 0));
    vt.push_back(v(0,0,1,0, 6'd9, 32'h1234, 6'd7, 1, 1, 0,1,0,0,0, 0, 0, 0));
    vt.push_back(v(0,0,0,0, 6'd0, 32'h0, 6'd0, 1, 1, 1,1,1,0,1, 6'd9, 32'h1234, 6'd7));
    vt.push_back(v(0,0,0,0, 6'd0, 32'h0, 6'd0, 0, 1, 0,1,0,0,0, 0, 0, 0));
    vt.push_back(v(0,0,1,1, 6'd10, 32'hA1, 6'd1, 0, 1, 0,1,0,0,0, 0, 0, 0));
    vt.push_back(v(0,0,1,1, 6'd11, 32'hA2, 6'd2, 0, 1, 1,1,1,0,0, 6'd10, 32'hA1, 6'd1));
    vt.push_back(v(0,0,1,1, 6'd12, 32'hA3, 6'd3, 0, 1, 2,1,1,0,0, 6'd10, 32'hA1, 6'd1));
    vt.push_back(v(0,1,1,1, 6'd13, 32'hA9, 6'd9, 0, 1, 3,1,1,0,0, 6'd10, 32'hA1, 6'd1));
    vt.push_back(v(0,0,0,0, 6'd0, 32'h0, 6'd0, 1, 1, 0,1,0,0,0, 0, 0, 0));
    vt.push_back(v(0,0,1,1, 6'd14, 32'hB4, 6'd4, 0, 1, 0,1,0,0,0, 0, 0, 0));
    vt.push_back(v(0,1,0,0, 6'd0, 32'h0, 6'd0, 1, 1, 1,1,1,1,1, 6'd14, 32'hB4, 6'd4));
    vt.push_back(v(0,0,0,0, 6'd0, 32'h0, 6'd0, 1, 1, 0,1,0,0,0, 0, 0, 0));
    vt.push_back(v(0,0,1,1, 6'd15, 32'hC5, 6'd5, 0, 1, 0,1,0,0,0, 0, 0, 0));
    vt.push_back(v(1,0,1,1, 6'd16, 32'hC6, 6'd6, 0, 1, 1,1,1,0,0, 6'd15, 32'hC5, 6'd5));
    vt.push_back(v(0,0,0,0, 6'd0, 32'h0, 6'd0, 1, 1, 0,1,0,0,0, 0, 0, 0));

    foreach (vt[i]) begin
      drive(vt[i].rst, vt[i].flush, vt[i].iv, vt[i].wen, vt[i].addr, vt[i].data, vt[i].rob, vt[i].grant);
      if (vt[i].chk) begin
        chk($sformatf("v%0d_count", i), count, vt[i].e_cnt);
        chk($sformatf("v%0d_in_ready", i), in_ready, vt[i].e_rdy);
        chk($sformatf("v%0d_out_valid", i), out_valid, vt[i].e_vld);
        chk($sformatf("v%0d_prf_wen", i), prf_wen, vt[i].e_pwen);
        chk($sformatf("v%0d_rob_finish", i), rob_finish, vt[i].e_fin);
        if (vt[i].e_vld) begin
          chk($sformatf("v%0d_prf_addr", i), prf_addr, vt[i].e_addr);
          chk($sformatf("v%0d_prf_data", i), prf_data, vt[i].e_data);
          chk($sformatf("v%0d_rob_id", i), rob_id, vt[i].e_rob);
        end
      end
      step();
    end

    // Fill to DEPTH, then hold a fifth result against back-pressure.
    for (int r = 1; r <= 4; r++) begin
      drive(0, 0, 1, 1, 6'(r), 32'(r * 16), 6'(r), 0);
      step();
    end
    drive(0, 0, 1, 1, 6'd5, 32'h50, 6'd5, 0);
    chk("fill_count", count, 3'd4);
    chk("fill_in_ready", in_ready, 1'b0);
    step();
    chk("fill_hold_count", count, 3'd4);
    drive(0, 0, 1, 1, 6'd5, 32'h50, 6'd5, 1);
    chk("bp_ready_no_bypass", in_ready, 1'b0);
    chk("bp_pop1_rob", rob_id, 6'd1);
    chk("bp_pop1_fin", rob_finish, 1'b1);
    step();
    drive(0, 0, 1, 1, 6'd5, 32'h50, 6'd5, 1);
    chk("bp_count_after_pop", count, 3'd3);
    chk("bp_ready_after_pop", in_ready, 1'b1);
    chk("bp_pop2_rob", rob_id, 6'd2);
    step();
    drive(0, 0, 0, 0, 6'd0, 32'd0, 6'd0, 1);
    chk("bp_pushpop_count", count, 3'd3);
    chk("bp_pop3_rob", rob_id, 6'd3);
    step();
    chk("bp_pop4_rob", rob_id, 6'd4);
    step();
    chk("bp_pop5_rob", rob_id, 6'd5);
    chk("bp_pop5_data", prf_data, 32'h50);
    step();
    chk("bp_drained", out_valid, 1'b0);

    // Wrap-around with a repeating grant pattern, then long random traffic.
    mq.delete();
    run_model(30, 0);
    chk("wrap_all_drained", mq.size(), 0);
    run_model(600, 1);
    dummy = '{1'b0, 6'd0, 32'd0, 6'd0};
    for (int k = 0; k < 6; k++) model_cycle(1'b0, dummy, 1'b1, 1'b0, acc);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
